// File: rtl/execute_stage_if.sv
// Bus between decode, the execute stage and the memory stage.
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both high; valid never waits on ready, and the sender keeps all payload
// fields stable while valid is high and ready is low.
interface execute_stage_if #(
    parameter int W = 64
);
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   icode;
    logic [3:0]   ifun;
    logic [W-1:0] valC;
    logic [W-1:0] valA;
    logic [W-1:0] valB;
    logic [3:0]   dstE;
    logic [3:0]   dstM;

    logic         out_valid;
    logic         out_ready;
    logic [3:0]   out_icode;
    logic [W-1:0] out_valE;
    logic [W-1:0] out_valA;
    logic [3:0]   out_dstE;
    logic [3:0]   out_dstM;
    logic         out_cnd;
    logic         out_ins_err;

    modport slave (
        input  in_valid, icode, ifun, valC, valA, valB, dstE, dstM, out_ready,
        output in_ready, out_valid, out_icode, out_valE, out_valA,
               out_dstE, out_dstM, out_cnd, out_ins_err
    );

    modport master (
        output in_valid, icode, ifun, valC, valA, valB, dstE, dstM, out_ready,
        input  in_ready, out_valid, out_icode, out_valE, out_valA,
               out_dstE, out_dstM, out_cnd, out_ins_err
    );
endinterface

// File: rtl/execute_stage.sv
// Y86 execute stage: ALU, condition evaluation against an internal {OF,SF,ZF}
// register, and a valid/ready output register with bubble squash.
// Optional feature macro EXEC_IMUL_EN: opq ifun 4 becomes a W-step signed
// shift-add multiply that holds the stage in the MUL state.
module execute_stage #(
    parameter int W    = 64,
    parameter int STEP = W / 8
) (
    input  logic           clock,
    input  logic           reset_n,
    execute_stage_if.slave bus,
    input  logic           bubble,
    input  logic           cc_hold,
    output logic [2:0]     cc,
    output logic           state_dbg
);
    localparam logic [W-1:0] STEP_W = W'(STEP);

`ifdef EXEC_IMUL_EN
    typedef enum logic [0:0] {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;
`else
    typedef enum logic [0:0] {S_IDLE = 1'b0} state_t;
`endif

    state_t state, state_nxt;
    logic accept;
    logic cond, cond_ill, cnd_res;
    logic [W-1:0] alu_val, add_res, sub_res;
    logic alu_of, add_of, sub_of, is_op, is_mul, ill;

    logic         out_valid_q, out_cnd_q, out_ins_err_q;
    logic [3:0]   out_icode_q, out_dste_q, out_dstm_q;
    logic [W-1:0] out_vale_q, out_vala_q;

    assign bus.in_ready = (state == S_IDLE) && (!out_valid_q || bus.out_ready) && !bubble;
    assign accept       = bus.in_valid && bus.in_ready;
    assign state_dbg    = state;

    assign add_res = bus.valB + bus.valA;
    assign sub_res = bus.valB - bus.valA;
    assign add_of  = (bus.valB[W-1] == bus.valA[W-1]) && (add_res[W-1] != bus.valB[W-1]);
    assign sub_of  = (bus.valB[W-1] != bus.valA[W-1]) && (sub_res[W-1] != bus.valB[W-1]);

    // Branch/cmov condition from the current flags (cc = {OF,SF,ZF}).
    always_comb begin
        cond     = 1'b0;
        cond_ill = 1'b0;
        case (bus.ifun)
            4'd0:    cond = 1'b1;
            4'd1:    cond = (cc[1] ^ cc[2]) | cc[0];
            4'd2:    cond = cc[1] ^ cc[2];
            4'd3:    cond = cc[0];
            4'd4:    cond = !cc[0];
            4'd5:    cond = !(cc[1] ^ cc[2]);
            4'd6:    cond = !(cc[1] ^ cc[2]) && !cc[0];
            default: cond_ill = 1'b1;
        endcase
    end

    // Single-cycle ALU result, overflow flag and instruction classification.
    always_comb begin
        alu_val = '0;
        alu_of  = 1'b0;
        is_op   = 1'b0;
        is_mul  = 1'b0;
        ill     = 1'b0;
        case (bus.icode)
            4'h2:       begin alu_val = bus.valA; ill = cond_ill; end
            4'h3:       alu_val = bus.valC;
            4'h4, 4'h5: alu_val = bus.valC + bus.valB;
            4'h6: begin
                case (bus.ifun)
                    4'd0:    begin alu_val = add_res; alu_of = add_of; is_op = 1'b1; end
                    4'd1:    begin alu_val = sub_res; alu_of = sub_of; is_op = 1'b1; end
                    4'd2:    begin alu_val = bus.valB & bus.valA; is_op = 1'b1; end
                    4'd3:    begin alu_val = bus.valB ^ bus.valA; is_op = 1'b1; end
`ifdef EXEC_IMUL_EN
                    4'd4:    is_mul = 1'b1;
`endif
                    default: ill = 1'b1;
                endcase
            end
            4'h7:       ill = cond_ill;
            4'h8, 4'hA: alu_val = bus.valB - STEP_W;
            4'h9, 4'hB: alu_val = bus.valB + STEP_W;
            default:    alu_val = '0;
        endcase
        if (ill) alu_val = '0;
    end

    assign cnd_res = ((bus.icode == 4'h2) || (bus.icode == 4'h7)) && !cond_ill && cond;

`ifdef EXEC_IMUL_EN
    localparam int CW = $clog2(W);
    logic [2*W-1:0] mul_acc, mul_mcand, mul_sum, mul_prod;
    logic [W-1:0]   mul_mplier, mul_vala, a_mag, b_mag, mul_lo;
    logic [W:0]     mul_upper;
    logic [3:0]     mul_dste, mul_dstm;
    logic [CW-1:0]  mul_cnt;
    logic           mul_neg, mul_of, mul_last;

    assign a_mag     = bus.valA[W-1] ? -bus.valA : bus.valA;
    assign b_mag     = bus.valB[W-1] ? -bus.valB : bus.valB;
    assign mul_sum   = mul_acc + (mul_mplier[0] ? mul_mcand : '0);
    assign mul_prod  = mul_neg ? -mul_sum : mul_sum;
    assign mul_lo    = mul_prod[W-1:0];
    assign mul_upper = mul_prod[2*W-1:W-1];
    assign mul_of    = !((&mul_upper) || !(|mul_upper));
    assign mul_last  = (mul_cnt == CW'(W - 1));

    // Magnitude shift-add datapath; sign applied on the final step.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mul_acc    <= '0;
            mul_mcand  <= '0;
            mul_mplier <= '0;
            mul_neg    <= 1'b0;
            mul_cnt    <= '0;
            mul_vala   <= '0;
            mul_dste   <= 4'hF;
            mul_dstm   <= 4'hF;
        end else if (accept && is_mul) begin
            mul_acc    <= '0;
            mul_mcand  <= {{W{1'b0}}, b_mag};
            mul_mplier <= a_mag;
            mul_neg    <= bus.valA[W-1] ^ bus.valB[W-1];
            mul_cnt    <= '0;
            mul_vala   <= bus.valA;
            mul_dste   <= bus.dstE;
            mul_dstm   <= bus.dstM;
        end else if (state == S_MUL) begin
            mul_acc    <= mul_sum;
            mul_mcand  <= mul_mcand << 1;
            mul_mplier <= mul_mplier >> 1;
            mul_cnt    <= mul_cnt + 1'b1;
        end
    end
`endif

    // State register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state: enter MUL on an accepted multiply, leave after W steps or bubble.
    always_comb begin
        state_nxt = state;
        case (state)
`ifdef EXEC_IMUL_EN
            S_IDLE:  if (accept && is_mul) state_nxt = S_MUL;
            S_MUL:   if (bubble || mul_last) state_nxt = S_IDLE;
`endif
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output register: bubble first, then new results, then consumption.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q   <= 1'b0;
            out_icode_q   <= 4'h0;
            out_vale_q    <= '0;
            out_vala_q    <= '0;
            out_dste_q    <= 4'hF;
            out_dstm_q    <= 4'hF;
            out_cnd_q     <= 1'b0;
            out_ins_err_q <= 1'b0;
        end else if (bubble) begin
            out_valid_q <= 1'b0;
        end else if (accept && !is_mul) begin
            out_valid_q   <= 1'b1;
            out_icode_q   <= bus.icode;
            out_vale_q    <= alu_val;
            out_vala_q    <= bus.valA;
            out_dste_q    <= (bus.icode == 4'h2 && !cnd_res) ? 4'hF : bus.dstE;
            out_dstm_q    <= bus.dstM;
            out_cnd_q     <= cnd_res;
            out_ins_err_q <= ill;
        end else if (accept) begin
            out_valid_q <= 1'b0;
`ifdef EXEC_IMUL_EN
        end else if (state == S_MUL && mul_last) begin
            out_valid_q   <= 1'b1;
            out_icode_q   <= 4'h6;
            out_vale_q    <= mul_lo;
            out_vala_q    <= mul_vala;
            out_dste_q    <= mul_dste;
            out_dstm_q    <= mul_dstm;
            out_cnd_q     <= 1'b0;
            out_ins_err_q <= 1'b0;
`endif
        end else if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Condition codes: legal opq at accept, multiply at its final step.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cc <= 3'b001;
        end else if (!bubble && !cc_hold) begin
            if (accept && is_op)
                cc <= {alu_of, alu_val[W-1], alu_val == '0};
`ifdef EXEC_IMUL_EN
            else if (state == S_MUL && mul_last)
                cc <= {mul_of, mul_lo[W-1], mul_lo == '0};
`endif
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_icode   = out_icode_q;
    assign bus.out_valE    = out_vale_q;
    assign bus.out_valA    = out_vala_q;
    assign bus.out_dstE    = out_dste_q;
    assign bus.out_dstM    = out_dstm_q;
    assign bus.out_cnd     = out_cnd_q;
    assign bus.out_ins_err = out_ins_err_q;
endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage (W=64, STEP=8).
module tb_execute_stage;
    localparam int W = 64;

    logic       clock;
    logic       reset_n;
    logic       bubble;
    logic       cc_hold;
    logic [2:0] cc;
    logic       state_dbg;

    execute_stage_if #(.W(W)) bus ();

    execute_stage #(.W(W)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus),
        .bubble    (bubble),
        .cc_hold   (cc_hold),
        .cc        (cc),
        .state_dbg (state_dbg)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;
    logic sb_en = 1'b0;
    logic [W-1:0] exp_q[$];

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic idle();
        bus.in_valid = 1'b0;
        bus.icode    = 4'h1;
        bus.ifun     = 4'h0;
        bus.valC     = '0;
        bus.valA     = '0;
        bus.valB     = '0;
        bus.dstE     = 4'hF;
        bus.dstM     = 4'hF;
    endtask

    // Presents one instruction, waits for acceptance, returns just after the
    // accepting edge with in_valid still high (caller issues next or idles).
    task automatic issue(input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] c, input logic [63:0] a, input logic [63:0] b,
                         input logic [3:0] de, input logic [3:0] dm);
        int n;
        bus.icode = ic; bus.ifun = fn;
        bus.valC = c; bus.valA = a; bus.valB = b;
        bus.dstE = de; bus.dstM = dm;
        bus.in_valid = 1'b1;
        #1;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clock); #1;
            n++;
        end
        if (n >= 200) check("accept_timeout", 64'(bus.in_ready), 64'd1);
        @(negedge clock); #1;
    endtask

    // Idles and counts cycles with in_ready low (multiply duration).
    task automatic wait_ready(output int cnt);
        idle();
        cnt = 0;
        while (!bus.in_ready && cnt < 200) begin
            @(negedge clock); #1;
            cnt++;
        end
    endtask

    // scoreboard for the back-to-back stream
    always @(negedge clock) begin
        if (sb_en && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) check("sb_extra", 64'(exp_q.size()), 64'd1);
            else                   check("sb_valE", bus.out_valE, exp_q.pop_front());
        end
    end

    initial begin
        int cnt;
        int c0;
        reset_n = 1'b0; bubble = 1'b0; cc_hold = 1'b0;
        bus.out_ready = 1'b1;
        idle();
        repeat (2) @(negedge clock);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_out_valE", bus.out_valE, 64'd0);
        check("rst_out_dstE", 64'(bus.out_dstE), 64'hF);
        check("rst_out_dstM", 64'(bus.out_dstM), 64'hF);
        check("rst_cc", 64'(cc), 64'd1);
        reset_n = 1'b1; #1;
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        @(negedge clock); #1;

        // sub 3-5
        issue(4'h6, 4'h1, 0, 64'd5, 64'd3, 4'h2, 4'hF);
        check("sub_valE", bus.out_valE, 64'hFFFF_FFFF_FFFF_FFFE);
        check("sub_valid", 64'(bus.out_valid), 64'd1);
        check("sub_cc", 64'(cc), 64'b010);
        check("sub_dstE", 64'(bus.out_dstE), 64'h2);

        // signed overflow add, then conditional moves on the new flags
        issue(4'h6, 4'h0, 0, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, 4'h4, 4'hF);
        check("add_valE", bus.out_valE, 64'h8000_0000_0000_0000);
        check("add_cc", 64'(cc), 64'b110);
        issue(4'h2, 4'h2, 0, 64'h55, 0, 4'h3, 4'hF);
        check("cmovl_cnd", 64'(bus.out_cnd), 64'd0);
        check("cmovl_dstE", 64'(bus.out_dstE), 64'hF);
        check("cmovl_valE", bus.out_valE, 64'h55);
        issue(4'h2, 4'h5, 0, 64'h66, 0, 4'h3, 4'hF);
        check("cmovge_cnd", 64'(bus.out_cnd), 64'd1);
        check("cmovge_dstE", 64'(bus.out_dstE), 64'h3);
        issue(4'h7, 4'h1, 64'h400, 0, 0, 4'hF, 4'hF);
        check("jle_cnd", 64'(bus.out_cnd), 64'd0);
        check("jle_valE", bus.out_valE, 64'd0);

        // push held under back-pressure
        issue(4'hA, 4'h0, 0, 64'hAB, 64'h100, 4'h4, 4'hF);
        bus.out_ready = 1'b0;
        idle(); bus.in_valid = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("push_held_valid", 64'(bus.out_valid), 64'd1);
            check("push_held_valE", bus.out_valE, 64'hF8);
            check("push_held_ready", 64'(bus.in_ready), 64'd0);
            @(negedge clock); #1;
        end
        bus.out_ready = 1'b1;
        @(negedge clock); #1;
        check("nop_after_push", 64'(bus.out_icode), 64'h1);
        check("nop_valid", 64'(bus.out_valid), 64'd1);
        idle();
        @(negedge clock); #1;
        check("drained_valid", 64'(bus.out_valid), 64'd0);

        // bubble squashes the held result and blocks xor
        bus.out_ready = 1'b0;
        issue(4'h3, 4'h0, 64'h1234, 0, 0, 4'h5, 4'hF);
        check("irmov_valE", bus.out_valE, 64'h1234);
        bus.icode = 4'h6; bus.ifun = 4'h3; bus.valA = 0; bus.valB = 0; bus.dstE = 4'h6;
        bubble = 1'b1;
        @(negedge clock); #1;
        check("bubble_valid", 64'(bus.out_valid), 64'd0);
        check("bubble_cc", 64'(cc), 64'b110);
        bubble = 1'b0; bus.out_ready = 1'b1;
        issue(4'h6, 4'h3, 0, 0, 0, 4'h6, 4'hF);
        check("xor_valE", bus.out_valE, 64'd0);
        check("xor_cc", 64'(cc), 64'b001);

        // illegal function codes
        issue(4'h6, 4'h6, 0, 64'd1, 64'd2, 4'h7, 4'hF);
        check("ill_op_err", 64'(bus.out_ins_err), 64'd1);
        check("ill_op_valE", bus.out_valE, 64'd0);
        check("ill_op_cc", 64'(cc), 64'b001);
        issue(4'h7, 4'h9, 64'h40, 0, 0, 4'hF, 4'hF);
        check("ill_jxx_err", 64'(bus.out_ins_err), 64'd1);
        check("ill_jxx_cnd", 64'(bus.out_cnd), 64'd0);
`ifndef EXEC_IMUL_EN
        issue(4'h6, 4'h4, 0, 64'd6, 64'd7, 4'h7, 4'hF);
        check("ill_mul_err", 64'(bus.out_ins_err), 64'd1);
        check("ill_mul_valE", bus.out_valE, 64'd0);
`endif

        // cc_hold suppresses the flag write
        cc_hold = 1'b1;
        issue(4'h6, 4'h0, 0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'h1, 4'hF);
        check("hold_valE", bus.out_valE, 64'd0);
        check("hold_cc", 64'(cc), 64'b001);
        cc_hold = 1'b0;
        issue(4'h6, 4'h0, 0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'h1, 4'hF);
        check("nohold_cc", 64'(cc), 64'b101);
        issue(4'h2, 4'h3, 0, 64'h77, 0, 4'h9, 4'hF);
        check("cmove_cnd", 64'(bus.out_cnd), 64'd1);
        check("cmove_dstE", 64'(bus.out_dstE), 64'h9);
        idle();
        @(negedge clock); #1;

        // back-to-back stream through the scoreboard
        sb_en = 1'b1;
        exp_q.push_back(64'h30);   exp_q.push_back(64'h1008);
        exp_q.push_back(64'hF8);   exp_q.push_back(64'h108);
        exp_q.push_back(64'h208);  exp_q.push_back(64'hF000);
        exp_q.push_back(64'h0);    exp_q.push_back(64'hDEAD);
        c0 = cyc;
        issue(4'h5, 4'h0, 64'h10, 0, 64'h20, 4'hF, 4'h3);
        issue(4'h4, 4'h0, 64'h8, 0, 64'h1000, 4'hF, 4'hF);
        issue(4'h8, 4'h0, 0, 0, 64'h100, 4'h4, 4'hF);
        issue(4'h9, 4'h0, 0, 0, 64'h100, 4'h4, 4'hF);
        issue(4'hB, 4'h0, 0, 0, 64'h200, 4'h4, 4'h2);
        issue(4'h6, 4'h2, 0, 64'hF0F0, 64'hFF00, 4'h5, 4'hF);
        issue(4'h0, 4'h0, 64'h5, 0, 0, 4'hF, 4'hF);
        issue(4'h3, 4'h0, 64'hDEAD, 0, 0, 4'h6, 4'hF);
        check("stream_cycles", 64'(cyc - c0), 64'd8);
        idle();
        @(negedge clock); #1;
        sb_en = 1'b0;
        check("sb_drained", 64'(exp_q.size()), 64'd0);
        check("and_cc", 64'(cc), 64'b000);

`ifdef EXEC_IMUL_EN
        issue(4'h6, 4'h1, 0, 64'd5, 64'd3, 4'h2, 4'hF);
        check("pre_mul_cc", 64'(cc), 64'b010);
        issue(4'h6, 4'h4, 0, 64'd6, 64'd7, 4'h3, 4'hF);
        wait_ready(cnt);
        check("mul_busy_cycles", 64'(cnt), 64'd64);
        check("mul_valE", bus.out_valE, 64'd42);
        check("mul_valid", 64'(bus.out_valid), 64'd1);
        check("mul_cc", 64'(cc), 64'b000);
        issue(4'h6, 4'h4, 0, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 4'h3, 4'hF);
        wait_ready(cnt);
        check("mul_neg_valE", bus.out_valE, 64'hFFFF_FFFF_FFFF_FFF1);
        check("mul_neg_cc", 64'(cc), 64'b010);
        issue(4'h6, 4'h4, 0, 64'd2, 64'h4000_0000_0000_0000, 4'h3, 4'hF);
        wait_ready(cnt);
        check("mul_ovf_valE", bus.out_valE, 64'h8000_0000_0000_0000);
        check("mul_ovf_cc", 64'(cc), 64'b110);
        @(negedge clock); #1;
        issue(4'h6, 4'h4, 0, 64'd2, 64'd3, 4'h3, 4'hF);
        idle();
        repeat (9) @(negedge clock);
        bubble = 1'b1;
        @(negedge clock); #1;
        bubble = 1'b0;
        check("mul_abort_state", 64'(state_dbg), 64'd0);
        cnt = 0;
        for (int i = 0; i < 70; i++) begin
            if (bus.out_valid) cnt++;
            @(negedge clock); #1;
        end
        check("mul_abort_no_out", 64'(cnt), 64'd0);
        check("mul_abort_cc", 64'(cc), 64'b110);
`endif

        // asynchronous reset with a held result
        bus.out_ready = 1'b0;
        issue(4'h3, 4'h0, 64'h99, 0, 0, 4'h2, 4'hF);
        idle();
        check("pre_reset_valid", 64'(bus.out_valid), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(bus.out_valid), 64'd0);
        check("async_rst_cc", 64'(cc), 64'b001);
        check("async_rst_dstE", 64'(bus.out_dstE), 64'hF);
        @(negedge clock);
        reset_n = 1'b1; bus.out_ready = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
